// File: rtl/audio_playback_ctrl.sv
// audio_playback_ctrl: walks the flash audio sample region one word at a time.
// For each word it issues a single read, latches the returned 32-bit word and
// passes it to the two-sample audio FSM with a start/finish handshake. It then
// steps the address forward or backward.
// Build option PLAYBACK_LOOP_EN: when defined, the address wraps at the region
// boundary and playback continues. When undefined, playback stops at the
// boundary and waits for restart.
module audio_playback_ctrl #(
  parameter int                ADDR_W    = 23,
  parameter logic [ADDR_W-1:0] LAST_ADDR = 23'h7FFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic              dir,
  input  logic              restart,
  output logic              flash_read,
  input  logic              flash_waitrequest,
  output logic [ADDR_W-1:0] flash_address,
  input  logic              flash_readdatavalid,
  input  logic [31:0]       flash_readdata,
  output logic [31:0]       sample_data,
  output logic              sample_start,
  input  logic              sample_finish,
  output logic              busy,
  output logic              end_flag
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REQ       = 3'd1,
    S_WAIT_DATA = 3'd2,
    S_START     = 3'd3,
    S_WAIT_FIN  = 3'd4,
    S_NEXT      = 3'd5
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              restart_pend;
  logic              halted;
  logic              restart_eff;
  logic              at_bound;
  logic              stop_at_bound;
  logic [ADDR_W-1:0] start_addr;

  logic [ADDR_W-1:0] addr_nxt;
  logic [31:0]       data_nxt;
  logic              end_nxt;
  logic              pend_nxt;
  logic              halted_nxt;
  logic              read_nxt;
  logic              start_nxt;
  logic              busy_nxt;

  // Neighbouring word address, wrapping at either end of the region.
  function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] a,
                                                  input logic              d);
    logic [ADDR_W-1:0] r;
    if (d) r = (a == '0) ? LAST_ADDR : a - ADDR_W'(1);
    else   r = (a == LAST_ADDR) ? '0 : a + ADDR_W'(1);
    return r;
  endfunction

  // A restart pulse seen this cycle counts as well as one parked earlier.
  assign restart_eff = restart | restart_pend;
  assign start_addr  = dir ? LAST_ADDR : '0;
  assign at_bound    = dir ? (flash_address == '0) : (flash_address == LAST_ADDR);

`ifdef PLAYBACK_LOOP_EN
  assign stop_at_bound = 1'b0;
`else
  assign stop_at_bound = at_bound;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; play/dir only matter in IDLE and NEXT.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (play && (!halted || restart_eff)) state_nxt = S_REQ;
      S_REQ:       if (!flash_waitrequest) state_nxt = S_WAIT_DATA;
      S_WAIT_DATA: if (flash_readdatavalid) state_nxt = S_START;
      S_START:     state_nxt = S_WAIT_FIN;
      S_WAIT_FIN:  if (sample_finish) state_nxt = S_NEXT;
      S_NEXT: begin
        if (!restart_eff && stop_at_bound) state_nxt = S_IDLE;
        else if (play)                     state_nxt = S_REQ;
        else                               state_nxt = S_IDLE;
      end
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs and bookkeeping flags.
  always_comb begin
    addr_nxt   = flash_address;
    data_nxt   = sample_data;
    end_nxt    = 1'b0;
    pend_nxt   = restart_pend | restart;
    halted_nxt = halted;
    read_nxt   = (state_nxt == S_REQ);
    start_nxt  = (state_nxt == S_START);
    busy_nxt   = (state_nxt != S_IDLE);
    case (state)
      S_IDLE: begin
        if (restart_eff) begin
          addr_nxt   = start_addr;
          pend_nxt   = 1'b0;
          halted_nxt = 1'b0;
        end
      end
      S_WAIT_DATA: begin
        if (flash_readdatavalid) data_nxt = flash_readdata;
      end
      S_NEXT: begin
        if (restart_eff) begin
          addr_nxt = start_addr;
          pend_nxt = 1'b0;
        end else if (stop_at_bound) begin
          end_nxt    = 1'b1;
          halted_nxt = 1'b1;
        end else begin
          addr_nxt = step_addr(flash_address, dir);
          end_nxt  = at_bound;
        end
      end
      default: ;
    endcase
  end

  // Output and flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flash_read    <= 1'b0;
      flash_address <= '0;
      sample_data   <= '0;
      sample_start  <= 1'b0;
      busy          <= 1'b0;
      end_flag      <= 1'b0;
      restart_pend  <= 1'b0;
      halted        <= 1'b0;
    end else begin
      flash_read    <= read_nxt;
      flash_address <= addr_nxt;
      sample_data   <= data_nxt;
      sample_start  <= start_nxt;
      busy          <= busy_nxt;
      end_flag      <= end_nxt;
      restart_pend  <= pend_nxt;
      halted        <= halted_nxt;
    end
  end

endmodule

// File: tb/tb_audio_playback_ctrl.sv
// tb_audio_playback_ctrl: randomized word-level bench for audio_playback_ctrl.
// The reference model tracks the expected word address, the halted condition
// and the busy/end_flag outcome of each word using modular arithmetic.
module tb_audio_playback_ctrl;

  localparam int ADDR_W = 23;
  localparam int LAST   = 'h7FFFF;

`ifdef PLAYBACK_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic              play;
  logic              dir;
  logic              restart;
  logic              flash_read;
  logic              flash_waitrequest;
  logic [ADDR_W-1:0] flash_address;
  logic              flash_readdatavalid;
  logic [31:0]       flash_readdata;
  logic [31:0]       sample_data;
  logic              sample_start;
  logic              sample_finish;
  logic              busy;
  logic              end_flag;

  int                vectors;
  int                miscompares;
  logic [ADDR_W-1:0] exp_addr;
  bit                halted;

  audio_playback_ctrl dut (
    .clk                 (clk),
    .reset               (reset),
    .play                (play),
    .dir                 (dir),
    .restart             (restart),
    .flash_read          (flash_read),
    .flash_waitrequest   (flash_waitrequest),
    .flash_address       (flash_address),
    .flash_readdatavalid (flash_readdatavalid),
    .flash_readdata      (flash_readdata),
    .sample_data         (sample_data),
    .sample_start        (sample_start),
    .sample_finish       (sample_finish),
    .busy                (busy),
    .end_flag            (end_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Serve one word from REQ through NEXT; play/dir/restart are applied in WAIT_FIN.
  task automatic service_word(input int stall, input int lat, input int fin,
                              input logic [31:0] data, input bit rs_mid,
                              input bit play_nxt, input bit dir_nxt);
    int guard;
    int a;
    bit bound;
    bit exp_end;
    bit exp_busy;
    guard = 0;
    while (flash_read !== 1'b1 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    vectors++;
    if (flash_read !== 1'b1) begin
      $display("FAIL read_req: flash_read=%b required 1 within 20 cycles", flash_read);
      miscompares++;
      return;
    end
    vectors++;
    if (flash_address !== exp_addr) begin
      $display("FAIL req_addr: flash_address=%h required %h", flash_address, exp_addr);
      miscompares++;
    end
    flash_waitrequest = (stall > 0);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      if (i == stall - 1) flash_waitrequest = 1'b0;
      vectors++;
      if (flash_read !== 1'b1 || flash_address !== exp_addr || sample_start !== 1'b0) begin
        $display("FAIL stall_hold: read=%b addr=%h start=%b required read=1 addr=%h start=0",
                 flash_read, flash_address, sample_start, exp_addr);
        miscompares++;
      end
    end
    @(posedge clk); #1;
    vectors++;
    if (flash_read !== 1'b0) begin
      $display("FAIL read_drop: flash_read=%b required 0 after accept", flash_read);
      miscompares++;
    end
    for (int i = 1; i < lat; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (flash_read !== 1'b0 || sample_start !== 1'b0) begin
        $display("FAIL wait_data: read=%b start=%b required 0 0", flash_read, sample_start);
        miscompares++;
      end
    end
    flash_readdatavalid = 1'b1;
    flash_readdata      = data;
    @(posedge clk); #1;
    vectors++;
    if (sample_start !== 1'b1 || sample_data !== data) begin
      $display("FAIL start: start=%b data=%h required 1 %h", sample_start, sample_data, data);
      miscompares++;
    end
    // a stray valid while START is showing must not disturb the latched word
    flash_readdata = ~data;
    @(posedge clk); #1;
    flash_readdatavalid = 1'b0;
    vectors++;
    if (sample_start !== 1'b0 || sample_data !== data || busy !== 1'b1) begin
      $display("FAIL wait_fin: start=%b data=%h busy=%b required 0 %h 1",
               sample_start, sample_data, busy, data);
      miscompares++;
    end
    play    = play_nxt;
    dir     = dir_nxt;
    restart = rs_mid;
    for (int i = 1; i < fin; i++) begin
      @(posedge clk); #1;
      restart = 1'b0;
      vectors++;
      if (sample_start !== 1'b0 || sample_data !== data || flash_read !== 1'b0) begin
        $display("FAIL fin_hold: start=%b data=%h read=%b required 0 %h 0",
                 sample_start, sample_data, flash_read, data);
        miscompares++;
      end
    end
    sample_finish = 1'b1;
    @(posedge clk); #1;
    sample_finish = 1'b0;
    restart       = 1'b0;
    // reference: the word just played decides the following address
    bound = dir_nxt ? (exp_addr == '0) : (int'(exp_addr) == LAST);
    a = int'(exp_addr);
    if (rs_mid) begin
      exp_addr = dir_nxt ? ADDR_W'(LAST) : '0;
      exp_end  = 1'b0;
      exp_busy = play_nxt;
    end else if (bound && !LOOP) begin
      exp_end  = 1'b1;
      exp_busy = 1'b0;
      halted   = 1'b1;
    end else begin
      a        = dir_nxt ? (a + LAST) % (LAST + 1) : (a + 1) % (LAST + 1);
      exp_addr = ADDR_W'(a);
      exp_end  = bound;
      exp_busy = play_nxt;
    end
    @(posedge clk); #1;
    vectors++;
    if (flash_address !== exp_addr || end_flag !== exp_end || busy !== exp_busy ||
        flash_read !== exp_busy) begin
      $display("FAIL next: addr=%h end=%b busy=%b read=%b required addr=%h end=%b busy=%b read=%b",
               flash_address, end_flag, busy, flash_read, exp_addr, exp_end, exp_busy, exp_busy);
      miscompares++;
    end
  endtask

  // Several idle cycles: nothing may start and the address must hold.
  task automatic check_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (flash_read !== 1'b0 || busy !== 1'b0 || end_flag !== 1'b0 ||
          flash_address !== exp_addr) begin
        $display("FAIL idle: read=%b busy=%b end=%b addr=%h required 0 0 0 %h",
                 flash_read, busy, end_flag, flash_address, exp_addr);
        miscompares++;
      end
    end
  endtask

  // Restart pulse issued while idle.
  task automatic pulse_restart(input bit d);
    dir     = d;
    restart = 1'b1;
    @(posedge clk); #1;
    restart  = 1'b0;
    exp_addr = d ? ADDR_W'(LAST) : '0;
    halted   = 1'b0;
    vectors++;
    if (flash_address !== exp_addr || end_flag !== 1'b0) begin
      $display("FAIL restart_idle: addr=%h end=%b required %h 0", flash_address, end_flag, exp_addr);
      miscompares++;
    end
  endtask

  task automatic check_reset_values(input string tag);
    vectors++;
    if (flash_read !== 1'b0 || flash_address !== '0 || sample_data !== 32'h0 ||
        sample_start !== 1'b0 || end_flag !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL %s: read=%b addr=%h data=%h start=%b end=%b busy=%b required all 0",
               tag, flash_read, flash_address, sample_data, sample_start, end_flag, busy);
      miscompares++;
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #2 check_reset_values("reset_async");
    @(posedge clk); #1;
    check_reset_values("reset_held");
    reset = 1'b1;
    exp_addr = '0;
    halted   = 1'b0;
    check_idle(2);
  endtask

  task automatic test_forward_run();
    play = 1'b1;
    dir  = 1'b0;
    service_word(0, 1, 3, 32'hA1B2C3D4, 1'b0, 1'b1, 1'b0);
    service_word(0, 1, 3, 32'hA1B2C3D4, 1'b0, 1'b1, 1'b0);
    service_word(0, 1, 3, 32'hA1B2C3D4, 1'b0, 1'b0, 1'b0);
    check_idle(3);
  endtask

  task automatic test_waitrequest_stall();
    play = 1'b1;
    service_word(4, 1, 2, $urandom, 1'b0, 1'b0, 1'b0);
    check_idle(2);
  endtask

  task automatic test_random_words();
    play = 1'b1;
    for (int w = 0; w < 24; w++) begin
      bit d;
      bit p;
      bit r;
      d = 1'($urandom_range(0, 1));
      if (exp_addr == '0) d = 1'b0;
      r = ($urandom_range(0, 7) == 0);
      if (r) d = 1'b0;
      p = ($urandom_range(0, 3) != 0);
      if (w == 23) p = 1'b0;
      service_word($urandom_range(0, 3), $urandom_range(1, 3), $urandom_range(1, 5),
                   $urandom, r, p, d);
      if (!p) begin
        check_idle(2);
        if (w != 23) play = 1'b1;
      end
    end
  endtask

  task automatic test_backward_wrap();
    play = 1'b0;
    pulse_restart(1'b0);
    play = 1'b1;
    service_word(0, 1, 2, $urandom, 1'b0, 1'b1, 1'b1);
    if (halted) begin
      check_idle(4);
      play = 1'b0;
      pulse_restart(1'b1);
    end else begin
      service_word(0, 1, 2, $urandom, 1'b0, 1'b0, 1'b1);
    end
  endtask

  task automatic test_forward_boundary();
    play = 1'b0;
    pulse_restart(1'b1);
    play = 1'b1;
    service_word(1, 2, 1, $urandom, 1'b0, 1'b1, 1'b0);
    if (halted) begin
      check_idle(4);
      play = 1'b0;
      pulse_restart(1'b0);
      play = 1'b1;
    end
    service_word(0, 1, 2, $urandom, 1'b0, 1'b0, 1'b0);
    check_idle(1);
  endtask

  task automatic test_pause_restart();
    play = 1'b1;
    dir  = 1'b0;
    for (int k = 0; k < 8 && exp_addr != ADDR_W'(5); k++)
      service_word(0, 1, 1, $urandom, 1'b0, 1'b1, 1'b0);
    service_word(0, 1, 3, $urandom, 1'b1, 1'b0, 1'b0);
    check_idle(5);
  endtask

  task automatic test_reset_mid_read();
    int guard;
    play = 1'b1;
    dir  = 1'b0;
    service_word(0, 1, 1, 32'h5A5A0F0F, 1'b0, 1'b1, 1'b0);
    guard = 0;
    while (flash_read !== 1'b1 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    flash_waitrequest = 1'b0;
    @(posedge clk); #1;
    play = 1'b0;
    #3 reset = 1'b0;
    #1 check_reset_values("reset_mid_read");
    flash_readdatavalid = 1'b1;
    flash_readdata      = 32'hDEADBEEF;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    flash_readdatavalid = 1'b0;
    check_reset_values("late_valid");
    exp_addr = '0;
    halted   = 1'b0;
    check_idle(2);
  endtask

  initial begin
    vectors             = 0;
    miscompares         = 0;
    reset               = 1'b1;
    play                = 1'b0;
    dir                 = 1'b0;
    restart             = 1'b0;
    flash_waitrequest   = 1'b0;
    flash_readdatavalid = 1'b0;
    flash_readdata      = 32'h0;
    sample_finish       = 1'b0;
    exp_addr            = '0;
    halted              = 1'b0;
    test_reset();
    test_forward_run();
    test_waitrequest_stall();
    test_random_words();
    test_backward_wrap();
    test_forward_boundary();
    test_pause_restart();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
